// File: rtl/traffic_phase_scheduler.sv
// Traffic phase scheduler: round-robin GREEN -> YELLOW -> ALL-RED sequencing over NUM_DIR
// approaches, with empty-approach skipping and queue-driven green extension.
// Optional feature macro: TLC_EMERGENCY_EN adds emergency preemption (EMERG_HOLD state).
module traffic_phase_scheduler #(
    parameter int unsigned NUM_DIR     = 4,
    parameter int unsigned TIMER_W     = 8,
    parameter int unsigned T_MIN_GREEN = 10,
    parameter int unsigned T_MAX_GREEN = 30,
    parameter int unsigned T_YELLOW    = 3,
    parameter int unsigned T_ALLRED    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_DIR-1:0]         sensor_1th,
    input  logic [NUM_DIR-1:0]         sensor_5th,
    input  logic [NUM_DIR-1:0]         emerg_req,
    output logic [2*NUM_DIR-1:0]       lights,
    output logic [$clog2(NUM_DIR)-1:0] active_dir,
    output logic                       phase_start
);

    localparam int unsigned DirW = $clog2(NUM_DIR);

    localparam logic [TIMER_W-1:0] TMax        = {TIMER_W{1'b1}};
    localparam logic [TIMER_W-1:0] TAllRedLast = TIMER_W'(T_ALLRED - 1);
    localparam logic [TIMER_W-1:0] TMinLast    = TIMER_W'(T_MIN_GREEN - 1);
    localparam logic [TIMER_W-1:0] TMaxLast    = TIMER_W'(T_MAX_GREEN - 1);
    localparam logic [TIMER_W-1:0] TYellowLast = TIMER_W'(T_YELLOW - 1);

    localparam logic [DirW-1:0]      DirLast   = DirW'(NUM_DIR - 1);
    localparam logic [2*NUM_DIR-1:0] LampGreen = (2*NUM_DIR)'(2'b10);
    localparam logic [2*NUM_DIR-1:0] LampYel   = (2*NUM_DIR)'(2'b01);

`ifdef TLC_EMERGENCY_EN
    typedef enum logic [1:0] {StAllRed, StGreen, StYellow, StEmergHold} state_e;
`else
    typedef enum logic [1:0] {StAllRed, StGreen, StYellow} state_e;
`endif

    state_e                 state_q, state_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic [DirW-1:0]        dir_q, dir_d;
    logic [2*NUM_DIR-1:0]   lights_q, lights_d;
    logic                   phase_start_q, phase_start_d;

    logic [NUM_DIR-1:0]     demand;
    logic                   rr_found;
    logic [DirW-1:0]        rr_pick;
    logic [DirW-1:0]        rr_cand;

`ifdef TLC_EMERGENCY_EN
    logic                   em_found;
    logic [DirW-1:0]        em_pick;
`else
    // Port is kept for drop-in compatibility but has no function in this build.
    logic                   unused_emerg;
    assign unused_emerg = ^emerg_req;
`endif

    // Round-robin search: start after the current owner, current owner checked last.
    always_comb begin
        demand   = sensor_1th | sensor_5th;
        rr_found = 1'b0;
        rr_pick  = dir_q;
        rr_cand  = '0;
        for (int unsigned k = 1; k <= NUM_DIR; k++) begin
            rr_cand = DirW'((32'(dir_q) + k) % NUM_DIR);
            if (!rr_found && demand[rr_cand]) begin
                rr_found = 1'b1;
                rr_pick  = rr_cand;
            end
        end
    end

`ifdef TLC_EMERGENCY_EN
    // Lowest-indexed emergency request wins.
    always_comb begin
        em_found = 1'b0;
        em_pick  = '0;
        for (int unsigned i = 0; i < NUM_DIR; i++) begin
            if (!em_found && emerg_req[DirW'(i)]) begin
                em_found = 1'b1;
                em_pick  = DirW'(i);
            end
        end
    end
`endif

    // Next-state, phase timer and registered-output precomputation.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;

        case (state_q)
            StAllRed: begin
                if (timer_q >= TAllRedLast) begin
`ifdef TLC_EMERGENCY_EN
                    if (em_found) begin
                        state_d = StEmergHold;
                        dir_d   = em_pick;
                    end else
`endif
                    if (rr_found) begin
                        state_d = StGreen;
                        dir_d   = rr_pick;
                    end
                end
            end
            StGreen: begin
`ifdef TLC_EMERGENCY_EN
                if (em_found && (em_pick != dir_q)) begin
                    state_d = StYellow;
                end else if (em_found) begin
                    state_d = StEmergHold;
                end else
`endif
                if (((timer_q >= TMinLast) && !sensor_5th[dir_q]) || (timer_q == TMaxLast)) begin
                    state_d = StYellow;
                end
            end
            StYellow: begin
                if (timer_q >= TYellowLast) begin
                    state_d = StAllRed;
                end
            end
`ifdef TLC_EMERGENCY_EN
            StEmergHold: begin
                if (!emerg_req[dir_q]) begin
                    state_d = StYellow;
                end
            end
`endif
            default: state_d = StAllRed;
        endcase

        // Timer restarts on every state change, otherwise counts up and saturates.
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q != TMax) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end

        // Lamps mirror the state being entered so the registered output matches the state.
        lights_d = '0;
        case (state_d)
            StGreen:     lights_d = LampGreen << {dir_d, 1'b0};
            StYellow:    lights_d = LampYel << {dir_d, 1'b0};
`ifdef TLC_EMERGENCY_EN
            StEmergHold: lights_d = LampGreen << {dir_d, 1'b0};
`endif
            default:     lights_d = '0;
        endcase

        // ALL_RED only ever exits into a green-showing state, so any exit is a phase start.
        phase_start_d = (state_q == StAllRed) && (state_d != StAllRed);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StAllRed;
            timer_q       <= '0;
            dir_q         <= DirLast;
            lights_q      <= '0;
            phase_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            dir_q         <= dir_d;
            lights_q      <= lights_d;
            phase_start_q <= phase_start_d;
        end
    end

    assign lights      = lights_q;
    assign active_dir  = dir_q;
    assign phase_start = phase_start_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed self-checking bench for traffic_phase_scheduler (default parameters).
// Cycle 0 is the first cycle after rst is deasserted; outputs are sampled 1 time unit after
// each rising edge.
module tb_traffic_phase_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] sensor_1th;
    logic [3:0] sensor_5th;
    logic [3:0] emerg_req;
    logic [7:0] lights;
    logic [1:0] active_dir;
    logic       phase_start;

    int tests_run;
    int tests_failed;

    traffic_phase_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .sensor_1th  (sensor_1th),
        .sensor_5th  (sensor_5th),
        .emerg_req   (emerg_req),
        .lights      (lights),
        .active_dir  (active_dir),
        .phase_start (phase_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected lamps for constant demand: green 10, yellow 3, all-red 2, first green at cycle 2.
    // rr=1 rotates dir0..dir3, rr=0 keeps dir0.
    function automatic logic [7:0] exp_lights(int c, bit rr);
        int         off;
        int         dir;
        logic [7:0] v;
        v = 8'h00;
        if (c >= 2) begin
            off = (c - 2) % 15;
            dir = rr ? (((c - 2) / 15) % 4) : 0;
            if (off < 10) begin
                v = 8'h02 << (2 * dir);
            end else if (off < 13) begin
                v = 8'h01 << (2 * dir);
            end
        end
        return v;
    endfunction

    function automatic logic exp_pstart(int c);
        return (c >= 2) && (((c - 2) % 15) == 0);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench positioned in cycle 0.
    task automatic do_reset();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        sensor_1th = 4'b0000;
        sensor_5th = 4'b0000;
        emerg_req  = 4'b0000;
        do_reset();
        tests_run++;
        if (lights !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_lights got %h exp %h", lights, 8'h00);
        end
        tests_run++;
        if (active_dir !== 2'd3) begin
            tests_failed++;
            $display("FAIL reset_active_dir got %0d exp %0d", active_dir, 3);
        end
        tests_run++;
        if (phase_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_phase_start got %b exp %b", phase_start, 1'b0);
        end
    endtask

    task automatic test_single_demand();
        sensor_1th = 4'b0001;
        sensor_5th = 4'b0000;
        emerg_req  = 4'b0000;
        do_reset();
        for (int c = 0; c <= 17; c++) begin
            if (c > 0) next_cycle();
            tests_run++;
            if (lights !== exp_lights(c, 1'b0)) begin
                tests_failed++;
                $display("FAIL single_lights c=%0d got %h exp %h", c, lights, exp_lights(c, 1'b0));
            end
            tests_run++;
            if (phase_start !== exp_pstart(c)) begin
                tests_failed++;
                $display("FAIL single_pstart c=%0d got %b exp %b", c, phase_start, exp_pstart(c));
            end
        end
    endtask

    task automatic test_round_robin();
        sensor_1th = 4'b1111;
        sensor_5th = 4'b0000;
        emerg_req  = 4'b0000;
        do_reset();
        for (int c = 0; c <= 72; c++) begin
            if (c > 0) next_cycle();
            tests_run++;
            if (lights !== exp_lights(c, 1'b1)) begin
                tests_failed++;
                $display("FAIL rr_lights c=%0d got %h exp %h", c, lights, exp_lights(c, 1'b1));
            end
            if (exp_pstart(c)) begin
                tests_run++;
                if (active_dir !== 2'(((c - 2) / 15) % 4)) begin
                    tests_failed++;
                    $display("FAIL rr_active_dir c=%0d got %0d exp %0d", c, active_dir,
                             ((c - 2) / 15) % 4);
                end
                tests_run++;
                if (phase_start !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL rr_pstart c=%0d got %b exp %b", c, phase_start, 1'b1);
                end
            end
        end
    endtask

    task automatic test_extend();
        logic [7:0] exp;
        sensor_1th = 4'b0001;
        sensor_5th = 4'b0001;
        emerg_req  = 4'b0000;
        do_reset();
        for (int c = 0; c <= 53; c++) begin
            if (c > 0) next_cycle();
            // Second green starts at 37, so its timer reads 15 at cycle 52.
            if (c == 52) sensor_5th = 4'b0000;
            if (c < 2)        exp = 8'h00;
            else if (c <= 31) exp = 8'h02;
            else if (c <= 34) exp = 8'h01;
            else if (c <= 36) exp = 8'h00;
            else if (c <= 52) exp = 8'h02;
            else              exp = 8'h01;
            tests_run++;
            if (lights !== exp) begin
                tests_failed++;
                $display("FAIL extend_lights c=%0d got %h exp %h", c, lights, exp);
            end
        end
    endtask

    task automatic test_idle_then_demand();
        sensor_1th = 4'b0000;
        sensor_5th = 4'b0000;
        emerg_req  = 4'b0000;
        do_reset();
        for (int c = 0; c < 50; c++) begin
            if (c > 0) next_cycle();
            tests_run++;
            if ((lights !== 8'h00) || (phase_start !== 1'b0)) begin
                tests_failed++;
                $display("FAIL idle_lights c=%0d got %h/%b exp %h/%b", c, lights, phase_start,
                         8'h00, 1'b0);
            end
        end
        next_cycle();
        sensor_1th = 4'b0100;
        tests_run++;
        if (lights !== 8'h00) begin
            tests_failed++;
            $display("FAIL idle_assert_cycle got %h exp %h", lights, 8'h00);
        end
        next_cycle();
        tests_run++;
        if (lights !== 8'h20) begin
            tests_failed++;
            $display("FAIL idle_dir2_green got %h exp %h", lights, 8'h20);
        end
        tests_run++;
        if (active_dir !== 2'd2) begin
            tests_failed++;
            $display("FAIL idle_dir2_active got %0d exp %0d", active_dir, 2);
        end
        tests_run++;
        if (phase_start !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_dir2_pstart got %b exp %b", phase_start, 1'b1);
        end
        sensor_1th = 4'b0000;
    endtask

    task automatic test_mid_phase_reset();
        sensor_1th = 4'b0001;
        sensor_5th = 4'b0000;
        emerg_req  = 4'b0000;
        do_reset();
        repeat (7) next_cycle();
        tests_run++;
        if (lights !== 8'h02) begin
            tests_failed++;
            $display("FAIL midrst_pre got %h exp %h", lights, 8'h02);
        end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        tests_run++;
        if ((lights !== 8'h00) || (active_dir !== 2'd3) || (phase_start !== 1'b0)) begin
            tests_failed++;
            $display("FAIL midrst_state got %h/%0d/%b exp %h/%0d/%b", lights, active_dir,
                     phase_start, 8'h00, 3, 1'b0);
        end
        for (int c = 0; c <= 17; c++) begin
            if (c > 0) next_cycle();
            tests_run++;
            if (lights !== exp_lights(c, 1'b0)) begin
                tests_failed++;
                $display("FAIL midrst_lights c=%0d got %h exp %h", c, lights, exp_lights(c, 1'b0));
            end
        end
    endtask

    task automatic test_emergency();
        logic [7:0] exp;
        sensor_1th = 4'b0001;
        sensor_5th = 4'b0000;
        emerg_req  = 4'b0000;
        do_reset();
        repeat (5) next_cycle();
        emerg_req = 4'b1000;
`ifdef TLC_EMERGENCY_EN
        for (int c = 5; c <= 21; c++) begin
            if (c > 5) next_cycle();
            if (c == 20) emerg_req = 4'b0000;
            if (c == 5)       exp = 8'h02;
            else if (c <= 8)  exp = 8'h01;
            else if (c <= 10) exp = 8'h00;
            else if (c <= 20) exp = 8'h80;
            else              exp = 8'h40;
            tests_run++;
            if (lights !== exp) begin
                tests_failed++;
                $display("FAIL emerg_lights c=%0d got %h exp %h", c, lights, exp);
            end
            if (c == 11) begin
                tests_run++;
                if ((active_dir !== 2'd3) || (phase_start !== 1'b1)) begin
                    tests_failed++;
                    $display("FAIL emerg_grant got %0d/%b exp %0d/%b", active_dir, phase_start,
                             3, 1'b1);
                end
            end
        end
`else
        for (int c = 5; c <= 17; c++) begin
            if (c > 5) next_cycle();
            exp = exp_lights(c, 1'b0);
            tests_run++;
            if (lights !== exp) begin
                tests_failed++;
                $display("FAIL emerg_ignored c=%0d got %h exp %h", c, lights, exp);
            end
        end
`endif
        emerg_req = 4'b0000;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        sensor_1th   = 4'b0000;
        sensor_5th   = 4'b0000;
        emerg_req    = 4'b0000;
        test_reset();
        test_single_demand();
        test_round_robin();
        test_extend();
        test_idle_then_demand();
        test_mid_phase_reset();
        test_emergency();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
